gpu_cmd_scheduler: RTL

Command scheduler between the host command interface and `gpu_decoder`. It buffers incoming opcode/parameter words in a small FIFO and issues them to the decoder as single-cycle `command` pulses. After each draw opcode it stalls issue until the rasterizer reports `finished`. A watchdog aborts a draw wait that never completes.

---
 rtl/gpu_cmd_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_scheduler.sv
// Command scheduler: buffers host opcode/parameter words in a small FIFO and
// issues them to the decoder as one-cycle command pulses. Draw opcodes stall
// further issue until the rasterizer reports finished, guarded by a watchdog.
module gpu_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cmd_valid_i,
  input  logic [3:0]                    cmd_opcode_i,
  input  logic [24:0]                   cmd_params_i,
  output logic                          cmd_ready_o,
  input  logic                          finished_i,
  input  logic                          abort_i,
  output logic [3:0]                    opcode_o,
  output logic [24:0]                   parameters_o,
  output logic                          command_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [AW:0]   FullCount = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [CW-1:0] WdLast    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] WdOne     = CW'(1);

  typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            timeout_set;

  logic [28:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [28:0]     head;
  logic            head_is_draw;
  logic            push, pop;

  logic            command_q;
  logic            timeout_q;
  logic [3:0]      opcode_q;
  logic [24:0]     params_q;

  assign head         = mem_q[rd_ptr_q];
  // Draw opcodes occupy 4'b0100..4'b0111.
  assign head_is_draw = (head[28:27] == 2'b01);

  // State register and watchdog counter; abort drops any pending draw wait.
  always_ff @(posedge clk) begin
    if (!n_rst || abort_i) begin
      state_q  <= StIdle;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Next-state: enter the draw wait on a draw pop, leave on finished or timeout.
  always_comb begin
    state_d     = state_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      StIdle: begin
        if ((count_q != '0) && head_is_draw) begin
          state_d  = StWaitDone;
          wd_cnt_d = '0;
        end
      end
      StWaitDone: begin
        // finished_i takes precedence over an expiring watchdog.
        if (finished_i) begin
          state_d = StIdle;
        end else if (wd_cnt_q == WdLast) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          wd_cnt_d = wd_cnt_q + WdOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and status outputs; readiness looks only at the registered count.
  always_comb begin
    cmd_ready_o = n_rst && (count_q != FullCount);
    push        = cmd_valid_i && cmd_ready_o && !abort_i;
    pop         = (state_q == StIdle) && (count_q != '0);
    busy_o      = (count_q != '0) || (state_q == StWaitDone);
  end

  // FIFO pointers, occupancy and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      command_q <= 1'b0;
      timeout_q <= 1'b0;
      opcode_q  <= '0;
      params_q  <= '0;
    end else if (abort_i) begin
      // Abort flushes the queue but leaves the last issued word visible.
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      command_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
      command_q <= pop;
      if (pop) begin
        opcode_q <= head[28:25];
        params_q <= head[24:0];
      end
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_opcode_i, cmd_params_i};
  end

  assign command_o    = command_q;
  assign timeout_o    = timeout_q;
  assign opcode_o     = opcode_q;
  assign parameters_o = params_q;
  assign fifo_count_o = count_q;

endmodule
